uart_receiver: RTL and testbench
================================

# uart_receiver

Asynchronous serial receiver forming the downstream stage of the UART transmitter: it deserialises frames from the `rx` line using the same frame-format and clock-divisor encoding, checks parity and stop bits, and presents each received character on a valid/acknowledge interface. It sits between the board-level RX pin and the host-side command logic of the tester.

## Interface
- `CLOCK_DIVISOR_WIDTH`, 24, width of `clockDivisor`; bit period = 4*clockDivisor+2 clk cycles
- `clk`  input  1  system clock, all logic on rising edge
- `rstN`  input  1  asynchronous, active-low reset
- `rx`  input  1  serial line, idle high, asynchronous to `clk`
- `dataBits`  input  2  data bits per frame = dataBits+5
- `hasParity`  input  1  frame carries a parity bit
- `parityMode`  input  2  00 space, 11 mark, 10 even, 01 odd
- `extraStopBit`  input  1  frame has two stop bits
- `clockDivisor`  input  CLOCK_DIVISOR_WIDTH  baud divisor
- `data`  output  8  received character, LSB-aligned, unused upper bits 0
- `valid`  output  1  `data`/error flags hold a character
- `readAck`  input  1  consumer takes the character
- `parityError`  output  1  parity mismatch for the held character
- `frameError`  output  1  a stop bit sampled low for the held character
- `overrun`  output  1  at least one character lost while `valid` was high
- `busy`  output  1  frame reception in progress

## Operation
- `rx` passes a 2-flop synchroniser; edge detection and sampling use the synchronised value only.
- Format inputs and `clockDivisor` are latched on start detection; changes mid-frame have no effect.
- States: IDLE, START, DATA, PAR, STOP1, STOP2.
- IDLE: falling edge on synchronised rx → START, counter cleared.
- START: sample at half period (2*div+1 cycles after edge). Low → DATA; high → false start, back to IDLE, no flags.
- DATA: sample every full period (4*div+2), shift in LSB first; after dataBits+5 bits → PAR if hasParity else STOP1.
- PAR: expected bit: space 0, mark 1, even = XOR of data bits, odd = XNOR; mismatch sets pending parity error.
- STOP1: sample; low sets pending frame error. → STOP2 if extraStopBit, else complete. STOP2: same check, then complete.
- Complete: if `valid` low, load `data`, flags, assert `valid`; if `valid` high, discard the new character, set `overrun`. Return to IDLE same cycle.
- `readAck` while `valid`: clears `valid`, `parityError`, `frameError`, `overrun` next cycle. `readAck` with `valid` low ignored.
- Completion coinciding with `readAck`: new character loads, `valid` stays high, no overrun.
- `clockDivisor`=0: period 2 cycles, half period 1 cycle; must operate.

## Timing
- Reset: all outputs 0, state IDLE, counters 0, synchroniser flops 1.
- Reset asserted mid-frame aborts immediately; no partial character delivered.
- Edge-to-START latency: 2 cycles synchroniser + 1 edge register.
- `valid` rises 1 cycle after the final stop-bit sample; `busy` falls the same cycle.
- Sample counter width CLOCK_DIVISOR_WIDTH+2; no wrap within a bit.
- A new start edge is accepted from the first cycle in IDLE.

## Configuration
- `UART_RX_MAJORITY_EN` defined: each bit value is the 2-of-3 majority of synchronised samples at centre-1, centre, centre+1; start validation also uses majority. Requires clockDivisor ≥ 1; with 0, single sample used.
- Not defined: single sample at bit centre.

## Structure
- Package `uart_pkg`: state encoding, parity-mode constants (PAR_SPACE, PAR_ODD, PAR_EVEN, PAR_MARK), data-bit count offset 5.
- Sub-module `uart_rx_sampler`: synchroniser, falling-edge detect, optional majority filter; outputs `rxSync`, `fallEdge`, `bitValue`.

## Test plan
- div=1 (6-cycle bit), 8N1, 0x55 → `valid`, data=0x55, all flags 0; `readAck` clears `valid`.
- div=2, 7 bits even parity, 0x41 with parity bit 0 → data=0x41, parityError=0; same frame with parity bit 1 → parityError=1.
- 8N2, second stop bit driven low, 0xA3 → data=0xA3, frameError=1.
- rx low for 2 cycles at div=3 → no `valid`, `busy` returns 0, next 0x0F frame received correctly.
- Two 8N1 frames 0x12, 0x34 without `readAck` → data=0x12, overrun=1; ack clears all.
- `rstN` pulsed low mid-DATA of 0xFF → outputs 0, next frame 0x81 received cleanly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding, parity modes, data-bit offset.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PAR,
    ST_STOP1,
    ST_STOP2
  } rx_state_t;

  localparam logic [1:0] PAR_SPACE = 2'b00;
  localparam logic [1:0] PAR_ODD   = 2'b01;
  localparam logic [1:0] PAR_EVEN  = 2'b10;
  localparam logic [1:0] PAR_MARK  = 2'b11;

  // Data bits per frame = dataBits + DATA_BITS_OFFSET
  localparam int DATA_BITS_OFFSET = 5;

endpackage

// File: rtl/uart_receiver_if.sv
// Host-side bundle of the UART receiver: serial line, frame format, character and status flags.
// Latency: none (wiring only).
// Backpressure: valid/readAck; an unread character causes later ones to be dropped with overrun.
interface uart_receiver_if #(
  parameter int CLOCK_DIVISOR_WIDTH = 24
);
  logic                           rx;
  logic [1:0]                     dataBits;
  logic                           hasParity;
  logic [1:0]                     parityMode;
  logic                           extraStopBit;
  logic [CLOCK_DIVISOR_WIDTH-1:0] clockDivisor;
  logic [7:0]                     data;
  logic                           valid;
  logic                           readAck;
  logic                           parityError;
  logic                           frameError;
  logic                           overrun;
  logic                           busy;

  modport master (
    output rx, dataBits, hasParity, parityMode, extraStopBit, clockDivisor, readAck,
    input  data, valid, parityError, frameError, overrun, busy
  );

  modport slave (
    input  rx, dataBits, hasParity, parityMode, extraStopBit, clockDivisor, readAck,
    output data, valid, parityError, frameError, overrun, busy
  );
endinterface

// File: rtl/uart_rx_sampler.sv
// RX front end: 2-flop synchroniser, falling-edge detect and bit-value filter (UART_RX_MAJORITY_EN).
// Latency: rxSync 2 cycles after rx; fallEdge the same cycle rxSync first reads low.
// Backpressure: none; free-running on every clock.
module uart_rx_sampler (
  input  logic i_clk,
  input  logic i_rstN,
  input  logic i_rx,
  output logic o_rxSync,
  output logic o_fallEdge,
  output logic o_bitValue
);

  logic r_sync1, r_sync2, r_sync3;

`ifdef UART_RX_MAJORITY_EN
  logic r_sync4;

  // Synchroniser plus two history taps; the line idles high so all flops reset to 1
  always_ff @(posedge i_clk or negedge i_rstN) begin
    if (!i_rstN) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_sync3 <= 1'b1;
      r_sync4 <= 1'b1;
    end else begin
      r_sync1 <= i_rx;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      r_sync4 <= r_sync3;
    end
  end

  // Evaluated one cycle after the bit centre, so the taps cover centre+1, centre, centre-1
  assign o_bitValue = (r_sync2 & r_sync3) | (r_sync2 & r_sync4) | (r_sync3 & r_sync4);
`else
  // Synchroniser plus one history tap for edge detection; idle-high reset
  always_ff @(posedge i_clk or negedge i_rstN) begin
    if (!i_rstN) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_sync3 <= 1'b1;
    end else begin
      r_sync1 <= i_rx;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  assign o_bitValue = r_sync2;
`endif

  assign o_rxSync   = r_sync2;
  assign o_fallEdge = r_sync3 & ~r_sync2;

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: deserialises rx frames, checks parity/stop bits, holds one character (UART_RX_MAJORITY_EN).
// Latency: valid rises 1 cycle after the final stop-bit sample; start seen 3 cycles after rx falls.
// Backpressure: valid/readAck; a character completing while valid is high and unacked is dropped, setting overrun.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLOCK_DIVISOR_WIDTH = 24
) (
  input logic            i_clk,
  input logic            i_rstN,
  uart_receiver_if.slave bus
);

  localparam int CNT_W = CLOCK_DIVISOR_WIDTH + 2;

  rx_state_t                      r_state, w_next;
  logic [CNT_W-1:0]               r_cnt;
  logic [CLOCK_DIVISOR_WIDTH-1:0] r_div;
  logic [1:0]                     r_bits, r_par_mode;
  logic                           r_par_en, r_two_stop;
  logic [7:0]                     r_shift;
  logic [2:0]                     r_bitcnt;
  logic                           r_perr, r_ferr;
  logic [7:0]                     r_data;
  logic                           r_valid, r_perr_out, r_ferr_out, r_overrun;

  logic             w_rx_sync, w_fall_edge, w_bit_value, w_bit;
  logic             w_hit, w_done, w_par_exp, w_maj_ofs, w_load;
  logic [CNT_W-1:0] w_half, w_period;
  logic [2:0]       w_last;

  uart_rx_sampler u_sampler (
    .i_clk      (i_clk),
    .i_rstN     (i_rstN),
    .i_rx       (bus.rx),
    .o_rxSync   (w_rx_sync),
    .o_fallEdge (w_fall_edge),
    .o_bitValue (w_bit_value)
  );

`ifdef UART_RX_MAJORITY_EN
  // Majority needs a neighbour on each side, so sample one cycle later; not possible at divisor 0
  assign w_maj_ofs = (r_div != '0);
`else
  assign w_maj_ofs = 1'b0;
`endif

  // A 2-cycle bit has no room for three samples, so divisor 0 always takes the single sample
  assign w_bit    = (r_div == '0) ? w_rx_sync : w_bit_value;
  assign w_half   = {1'b0, r_div, 1'b0} + CNT_W'(w_maj_ofs);
  assign w_period = {r_div, 2'b01};
  assign w_hit    = (r_state == ST_START) ? (r_cnt == w_half) : (r_cnt == w_period);
  assign w_last   = {1'b0, r_bits} + 3'(DATA_BITS_OFFSET - 1);
  assign w_load   = w_done && (!r_valid || bus.readAck);

  // State register
  always_ff @(posedge i_clk or negedge i_rstN) begin
    if (!i_rstN) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  // Next-state logic; w_done marks the final stop-bit sample
  always_comb begin
    w_next = r_state;
    w_done = 1'b0;
    case (r_state)
      ST_IDLE:  if (w_fall_edge) w_next = ST_START;
      ST_START: if (w_hit) w_next = w_bit ? ST_IDLE : ST_DATA;
      ST_DATA:  if (w_hit && (r_bitcnt == w_last)) w_next = r_par_en ? ST_PAR : ST_STOP1;
      ST_PAR:   if (w_hit) w_next = ST_STOP1;
      ST_STOP1: if (w_hit) begin
        if (r_two_stop) begin
          w_next = ST_STOP2;
        end else begin
          w_next = ST_IDLE;
          w_done = 1'b1;
        end
      end
      ST_STOP2: if (w_hit) begin
        w_next = ST_IDLE;
        w_done = 1'b1;
      end
      default:  w_next = ST_IDLE;
    endcase
  end

  // Expected parity bit; unused upper shift bits are zero so they do not disturb the XOR
  always_comb begin
    w_par_exp = 1'b0;
    case (r_par_mode)
      PAR_MARK: w_par_exp = 1'b1;
      PAR_EVEN: w_par_exp = ^r_shift;
      PAR_ODD:  w_par_exp = ~^r_shift;
      default:  w_par_exp = 1'b0;
    endcase
  end

  // Cycle counter within the current bit, restarted at every sample point
  always_ff @(posedge i_clk or negedge i_rstN) begin
    if (!i_rstN)                               r_cnt <= '0;
    else if ((r_state == ST_IDLE) || w_hit)    r_cnt <= '0;
    else                                       r_cnt <= r_cnt + CNT_W'(1);
  end

  // Frame datapath: latch format at start, shift data bits, accumulate pending errors
  always_ff @(posedge i_clk or negedge i_rstN) begin
    if (!i_rstN) begin
      r_div      <= '0;
      r_bits     <= '0;
      r_par_en   <= 1'b0;
      r_par_mode <= '0;
      r_two_stop <= 1'b0;
      r_shift    <= '0;
      r_bitcnt   <= '0;
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
    end else if ((r_state == ST_IDLE) && w_fall_edge) begin
      r_div      <= bus.clockDivisor;
      r_bits     <= bus.dataBits;
      r_par_en   <= bus.hasParity;
      r_par_mode <= bus.parityMode;
      r_two_stop <= bus.extraStopBit;
      r_shift    <= '0;
      r_bitcnt   <= '0;
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
    end else if (w_hit) begin
      case (r_state)
        ST_DATA: begin
          r_shift[r_bitcnt] <= w_bit;
          r_bitcnt          <= r_bitcnt + 3'd1;
        end
        ST_PAR:   if (w_bit != w_par_exp) r_perr <= 1'b1;
        ST_STOP1: if (!w_bit) r_ferr <= 1'b1;
        default:  ;
      endcase
    end
  end

  // Character holding register and host handshake
  always_ff @(posedge i_clk or negedge i_rstN) begin
    if (!i_rstN) begin
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_perr_out <= 1'b0;
      r_ferr_out <= 1'b0;
      r_overrun  <= 1'b0;
    end else if (w_load) begin
      r_data     <= r_shift;
      r_valid    <= 1'b1;
      r_perr_out <= r_perr;
      r_ferr_out <= r_ferr | ~w_bit;
      r_overrun  <= 1'b0;
    end else if (w_done) begin
      r_overrun  <= 1'b1;
    end else if (bus.readAck && r_valid) begin
      r_valid    <= 1'b0;
      r_perr_out <= 1'b0;
      r_ferr_out <= 1'b0;
      r_overrun  <= 1'b0;
    end
  end

  assign bus.data        = r_data;
  assign bus.valid       = r_valid;
  assign bus.parityError = r_perr_out;
  assign bus.frameError  = r_ferr_out;
  assign bus.overrun     = r_overrun;
  assign bus.busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: directed frames plus randomised formats against a frame-level reference model.
// Latency: waits are bounded by cycle budgets after each frame.
// Backpressure: readAck is driven by the bench after each character, or withheld to provoke overrun.
module tb_uart_receiver;
  import uart_pkg::*;

  logic clk  = 1'b0;
  logic rstN = 1'b0;
  always #5 clk = ~clk;

  uart_receiver_if #(.CLOCK_DIVISOR_WIDTH(24)) bus ();

  uart_receiver #(.CLOCK_DIVISOR_WIDTH(24)) dut (
    .i_clk  (clk),
    .i_rstN (rstN),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] exp_data;
  logic       exp_perr, exp_ferr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic set_format(input int div, input logic [1:0] db, input logic pe,
                            input logic [1:0] pm, input logic xs);
    bus.clockDivisor = 24'(div);
    bus.dataBits     = db;
    bus.hasParity    = pe;
    bus.parityMode   = pm;
    bus.extraStopBit = xs;
  endtask

  // Builds the bit sequence of one frame from the format rules, records the expected result, drives rx
  task automatic send_frame(input int div, input logic [1:0] db, input logic pe, input logic [1:0] pm,
                            input logic xs, input logic [7:0] d, input logic flip,
                            input logic s1low, input logic s2low);
    int         n;
    int         ones;
    logic [7:0] m;
    logic       p;
    logic       bits[$];
    n    = int'(db) + 5;
    m    = 8'hFF >> (8 - n);
    ones = $countones(d & m);
    case (pm)
      PAR_SPACE: p = 1'b0;
      PAR_MARK:  p = 1'b1;
      PAR_EVEN:  p = (ones % 2) == 1;
      default:   p = (ones % 2) == 0;
    endcase
    bits.push_back(1'b0);
    for (int i = 0; i < n; i++) bits.push_back(d[i]);
    if (pe) bits.push_back(p ^ flip);
    bits.push_back(~s1low);
    if (xs) bits.push_back(~s2low);
    exp_data = d & m;
    exp_perr = pe & flip;
    exp_ferr = s1low | (xs & s2low);
    set_format(div, db, pe, pm, xs);
    @(negedge clk);
    foreach (bits[i]) begin
      bus.rx = bits[i];
      repeat (4 * div + 2) @(negedge clk);
    end
    bus.rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_valid(input string tag);
    int k;
    k = 0;
    while (!bus.valid && k < 200) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_valid"}, 32'(bus.valid), 32'd1);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (bus.busy && k < 200) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_idle"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic check_char(input string tag, input logic ovr);
    check({tag, "_data"}, 32'(bus.data), 32'(exp_data));
    check({tag, "_perr"}, 32'(bus.parityError), 32'(exp_perr));
    check({tag, "_ferr"}, 32'(bus.frameError), 32'(exp_ferr));
    check({tag, "_ovr"}, 32'(bus.overrun), 32'(ovr));
  endtask

  task automatic do_ack(input string tag);
    @(negedge clk);
    bus.readAck = 1'b1;
    @(negedge clk);
    bus.readAck = 1'b0;
    check({tag, "_ack_valid"}, 32'(bus.valid), 32'd0);
    check({tag, "_ack_flags"},
          32'({bus.parityError, bus.frameError, bus.overrun}), 32'd0);
  endtask

  initial begin
    bus.rx      = 1'b1;
    bus.readAck = 1'b0;
    set_format(0, 2'd3, 1'b0, PAR_SPACE, 1'b0);
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(bus.valid), 32'd0);
    check("rst_data", 32'(bus.data), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_flags", 32'({bus.parityError, bus.frameError, bus.overrun}), 32'd0);
    rstN = 1'b1;
    repeat (2) @(negedge clk);

    // 8N1 at divisor 1
    send_frame(1, 2'd3, 1'b0, PAR_SPACE, 1'b0, 8'h55, 1'b0, 1'b0, 1'b0);
    wait_valid("t1");
    check_char("t1", 1'b0);
    do_ack("t1");

    // 7 bits, even parity, correct then corrupted parity bit
    send_frame(2, 2'd2, 1'b1, PAR_EVEN, 1'b0, 8'h41, 1'b0, 1'b0, 1'b0);
    wait_valid("t2a");
    check_char("t2a", 1'b0);
    do_ack("t2a");
    send_frame(2, 2'd2, 1'b1, PAR_EVEN, 1'b0, 8'h41, 1'b1, 1'b0, 1'b0);
    wait_valid("t2b");
    check_char("t2b", 1'b0);
    do_ack("t2b");

    // 8N2 with the second stop bit low
    send_frame(1, 2'd3, 1'b0, PAR_SPACE, 1'b1, 8'hA3, 1'b0, 1'b0, 1'b1);
    wait_valid("t3");
    check_char("t3", 1'b0);
    do_ack("t3");

    // Glitch shorter than half a bit is a false start
    set_format(3, 2'd3, 1'b0, PAR_SPACE, 1'b0);
    @(negedge clk);
    bus.rx = 1'b0;
    repeat (2) @(negedge clk);
    bus.rx = 1'b1;
    repeat (40) @(negedge clk);
    check("t4_glitch_valid", 32'(bus.valid), 32'd0);
    check("t4_glitch_busy", 32'(bus.busy), 32'd0);
    send_frame(3, 2'd3, 1'b0, PAR_SPACE, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b0);
    wait_valid("t4");
    check_char("t4", 1'b0);
    do_ack("t4");

    // Second character arrives while the first is unread
    send_frame(1, 2'd3, 1'b0, PAR_SPACE, 1'b0, 8'h12, 1'b0, 1'b0, 1'b0);
    wait_valid("t5a");
    send_frame(1, 2'd3, 1'b0, PAR_SPACE, 1'b0, 8'h34, 1'b0, 1'b0, 1'b0);
    wait_idle("t5b");
    check("t5_data", 32'(bus.data), 32'h12);
    check("t5_ovr", 32'(bus.overrun), 32'd1);
    check("t5_valid", 32'(bus.valid), 32'd1);
    do_ack("t5");

    // Reset in the middle of the data bits of 0xFF
    set_format(1, 2'd3, 1'b0, PAR_SPACE, 1'b0);
    @(negedge clk);
    bus.rx = 1'b0;
    repeat (6) @(negedge clk);
    bus.rx = 1'b1;
    repeat (12) @(negedge clk);
    check("t6_midframe_busy", 32'(bus.busy), 32'd1);
    rstN = 1'b0;
    @(negedge clk);
    check("t6_rst_outs",
          32'({bus.data, bus.valid, bus.busy, bus.parityError, bus.frameError, bus.overrun}), 32'd0);
    rstN = 1'b1;
    repeat (30) @(negedge clk);
    check("t6_after_valid", 32'(bus.valid), 32'd0);
    check("t6_after_busy", 32'(bus.busy), 32'd0);
    send_frame(1, 2'd3, 1'b0, PAR_SPACE, 1'b0, 8'h81, 1'b0, 1'b0, 1'b0);
    wait_valid("t6");
    check_char("t6", 1'b0);
    do_ack("t6");

    // Randomised formats, divisors 0..3, parity and stop-bit faults
    for (int i = 0; i < 25; i++) begin
      send_frame(int'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 3) == 0));
      wait_valid($sformatf("rnd%0d", i));
      check_char($sformatf("rnd%0d", i), 1'b0);
      do_ack($sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
